// File: rtl/mem_access_unit_if.sv
// Pipeline-side request/response signals plus the cache word interface of mem_access_unit.
// The slave modport is the unit's own view; master is the environment (pipeline + cache).
interface mem_access_unit_if;
    // Pipeline request side
    logic        req;
    logic        op_we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr_in;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;

    // Cache word side
    logic [31:0] addr;
    logic [31:0] din;
    logic        we;
    logic [31:0] dout;
    logic        rdy;

    modport slave (
        input  req, op_we, size, uns, addr_in, wdata, dout, rdy,
        output busy, done, err, rdata, addr, din, we
    );

    modport master (
        output req, op_we, size, uns, addr_in, wdata, dout, rdy,
        input  busy, done, err, rdata, addr, din, we
    );
endinterface

// File: rtl/mem_access_unit.sv
// Byte/half/word load-store unit over a word-wide cache; sub-word stores are read-merge-write.
// Cache address/data/we are held stable from issue until RDY is sampled high.
module mem_access_unit #(
    parameter int unsigned SETTLE = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    mem_access_unit_if.slave bus_io
);

    typedef enum logic [2:0] {
        StIdle,
        StRdSettle,
        StRdWait,
        StWrSettle,
        StWrWait,
        StFin
    } state_e;

    localparam logic [2:0] CntLast = 3'(SETTLE - 1);

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        op_we_q, op_we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [1:0]  lane_q, lane_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] din_q, din_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic misaligned;
    logic settle_last;

    // Select the addressed lane(s) and extend to 32 bits.
    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] sz,
                                            input logic [1:0] lane, input logic un);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{lane, 3'b000} +: 8];
        h = lane[1] ? w[31:16] : w[15:0];
        case (sz)
            2'b00:   extract = {{24{~un & b[7]}}, b};
            2'b01:   extract = {{16{~un & h[15]}}, h};
            default: extract = w;
        endcase
    endfunction

    // Overlay right-aligned store data onto the word read back from the cache.
    function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] wd,
                                          input logic [1:0] sz, input logic [1:0] lane);
        logic [31:0] m;
        m = w;
        case (sz)
            2'b00: m[{lane, 3'b000} +: 8] = wd[7:0];
            2'b01: begin
                if (lane[1]) m[31:16] = wd[15:0];
                else         m[15:0]  = wd[15:0];
            end
            default: ;
        endcase
        merge = m;
    endfunction

    // size[1] covers both word and the reserved encoding, which behaves as word.
    assign misaligned = ((bus_io.size == 2'b01) && bus_io.addr_in[0]) ||
                        (bus_io.size[1] && (bus_io.addr_in[1:0] != 2'b00));
    assign settle_last = (cnt_q == CntLast);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_we_d = op_we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        lane_d  = lane_q;
        wdata_d = wdata_q;
        addr_d  = addr_q;
        din_d   = din_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        unique case (state_q)
            StIdle: begin
                if (bus_io.req) begin
                    op_we_d = bus_io.op_we;
                    size_d  = bus_io.size;
                    uns_d   = bus_io.uns;
                    lane_d  = bus_io.addr_in[1:0];
                    wdata_d = bus_io.wdata;
                    cnt_d   = 3'd0;
                    if (misaligned) begin
                        // No cache access at all: leave ADDR/DIN as they were.
                        err_d   = 1'b1;
                        state_d = StFin;
                    end else begin
                        err_d  = 1'b0;
                        addr_d = {bus_io.addr_in[31:2], 2'b00};
                        if (bus_io.op_we && bus_io.size[1]) begin
                            din_d   = bus_io.wdata;
                            state_d = StWrSettle;
                        end else begin
                            state_d = StRdSettle;
                        end
                    end
                end
            end

            StRdSettle: begin
                if (settle_last) state_d = StRdWait;
                else             cnt_d   = cnt_q + 3'd1;
            end

            StRdWait: begin
                if (bus_io.rdy) begin
                    if (op_we_q) begin
                        din_d   = merge(bus_io.dout, wdata_q, size_q, lane_q);
                        cnt_d   = 3'd0;
                        state_d = StWrSettle;
                    end else begin
                        rdata_d = extract(bus_io.dout, size_q, lane_q, uns_q);
                        state_d = StFin;
                    end
                end
            end

            StWrSettle: begin
                if (settle_last) state_d = StWrWait;
                else             cnt_d   = cnt_q + 3'd1;
            end

            StWrWait: begin
                if (bus_io.rdy) state_d = StFin;
            end

            StFin: begin
                state_d = StIdle;
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= 3'd0;
            op_we_q <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            lane_q  <= 2'b00;
            wdata_q <= 32'h0;
            addr_q  <= 32'h0;
            din_q   <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_we_q <= op_we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            lane_q  <= lane_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign bus_io.busy  = (state_q != StIdle) && (state_q != StFin);
    assign bus_io.done  = (state_q == StFin);
    assign bus_io.err   = (state_q == StFin) && err_q;
    assign bus_io.rdata = rdata_q;
    assign bus_io.addr  = addr_q;
    assign bus_io.din   = din_q;
    assign bus_io.we    = (state_q == StWrSettle) || (state_q == StWrWait);

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with SETTLE=1; the bench plays both pipeline and cache.
module tb_mem_access_unit;

    logic clk;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    mem_access_unit_if bus ();

    mem_access_unit #(.SETTLE(1)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Issue one request, then step until DONE (bounded). cyc = edges after the request edge.
    task automatic run(input logic wop, input logic [1:0] sz, input logic un,
                       input logic [31:0] a, input logic [31:0] wd,
                       output int cyc, output int wec,
                       output logic [31:0] dinw, output logic [31:0] addrw);
        bus.req     = 1'b1;
        bus.op_we   = wop;
        bus.size    = sz;
        bus.uns     = un;
        bus.addr_in = a;
        bus.wdata   = wd;
        step();
        bus.req = 1'b0;
        cyc   = 0;
        wec   = 0;
        dinw  = '0;
        addrw = '0;
        while (!bus.done && cyc < 50) begin
            if (bus.we) begin
                wec++;
                dinw  = bus.din;
                addrw = bus.addr;
            end
            step();
            cyc++;
        end
        chk("done_seen", {31'b0, bus.done}, 32'd1);
    endtask

    int          cyc;
    int          wec;
    logic [31:0] dinw;
    logic [31:0] addrw;

    initial begin
        rst         = 1'b1;
        bus.req     = 1'b0;
        bus.op_we   = 1'b0;
        bus.size    = 2'b00;
        bus.uns     = 1'b0;
        bus.addr_in = 32'h0;
        bus.wdata   = 32'h0;
        bus.dout    = 32'h8899AABB;
        bus.rdy     = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst_busy",  {31'b0, bus.busy}, 32'd0);
        chk("rst_done",  {31'b0, bus.done}, 32'd0);
        chk("rst_err",   {31'b0, bus.err},  32'd0);
        chk("rst_we",    {31'b0, bus.we},   32'd0);
        chk("rst_rdata", bus.rdata, 32'h0);
        chk("rst_addr",  bus.addr,  32'h0);
        chk("rst_din",   bus.din,   32'h0);

        // Load byte signed at 0x42, checked cycle by cycle.
        bus.req = 1'b1; bus.op_we = 1'b0; bus.size = 2'b00; bus.uns = 1'b0;
        bus.addr_in = 32'h42;
        step();
        bus.req = 1'b0;
        chk("lb_busy1", {31'b0, bus.busy}, 32'd1);
        chk("lb_addr",  bus.addr, 32'h40);
        chk("lb_we",    {31'b0, bus.we}, 32'd0);
        step();
        chk("lb_done_early", {31'b0, bus.done}, 32'd0);
        step();
        chk("lb_done",  {31'b0, bus.done}, 32'd1);
        chk("lb_busy2", {31'b0, bus.busy}, 32'd0);
        chk("lb_err",   {31'b0, bus.err},  32'd0);
        chk("lb_rdata", bus.rdata, 32'hFFFFFF99);
        step();
        chk("lb_done_pulse", {31'b0, bus.done}, 32'd0);
        chk("lb_rdata_hold", bus.rdata, 32'hFFFFFF99);

        run(1'b0, 2'b01, 1'b1, 32'h42, 32'h0, cyc, wec, dinw, addrw);
        chk("lhu_rdata", bus.rdata, 32'h00008899);
        chk("lhu_lat",   cyc, 32'd2);
        step();
        run(1'b0, 2'b01, 1'b0, 32'h40, 32'h0, cyc, wec, dinw, addrw);
        chk("lh_rdata", bus.rdata, 32'hFFFFAABB);
        step();
        run(1'b0, 2'b00, 1'b1, 32'h43, 32'h0, cyc, wec, dinw, addrw);
        chk("lbu_rdata", bus.rdata, 32'h00000088);
        step();
        run(1'b0, 2'b11, 1'b0, 32'h40, 32'h0, cyc, wec, dinw, addrw);
        chk("lrsv_rdata", bus.rdata, 32'h8899AABB);
        step();
        run(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, cyc, wec, dinw, addrw);
        chk("lw_rdata", bus.rdata, 32'h8899AABB);
        chk("lw_err",   {31'b0, bus.err}, 32'd0);
        chk("lw_wec",   wec, 32'd0);
        step();

        // Sub-word stores: read, merge, write; RDATA untouched.
        run(1'b1, 2'b00, 1'b0, 32'h41, 32'h0000005A, cyc, wec, dinw, addrw);
        chk("sb_lat",   cyc, 32'd4);
        chk("sb_wec",   wec, 32'd2);
        chk("sb_din",   dinw, 32'h88995ABB);
        chk("sb_addr",  addrw, 32'h40);
        chk("sb_err",   {31'b0, bus.err}, 32'd0);
        chk("sb_rdata", bus.rdata, 32'h8899AABB);
        chk("sb_we_fin", {31'b0, bus.we}, 32'd0);
        step();
        run(1'b1, 2'b01, 1'b0, 32'h42, 32'hFFFF1234, cyc, wec, dinw, addrw);
        chk("sh_din", dinw, 32'h1234AABB);
        chk("sh_lat", cyc, 32'd4);
        step();
        run(1'b1, 2'b10, 1'b0, 32'h44, 32'hDEADBEEF, cyc, wec, dinw, addrw);
        chk("sw_lat",  cyc, 32'd2);
        chk("sw_wec",  wec, 32'd2);
        chk("sw_din",  dinw, 32'hDEADBEEF);
        chk("sw_addr", addrw, 32'h44);
        step();

        // Misaligned requests finish at once with ERR and no cache access.
        run(1'b0, 2'b10, 1'b0, 32'h42, 32'h0, cyc, wec, dinw, addrw);
        chk("mis_lat",  cyc, 32'd0);
        chk("mis_err",  {31'b0, bus.err}, 32'd1);
        chk("mis_we",   {31'b0, bus.we},  32'd0);
        chk("mis_addr", bus.addr, 32'h44);
        step();
        chk("mis_err_clr", {31'b0, bus.err}, 32'd0);
        run(1'b1, 2'b01, 1'b0, 32'h43, 32'h0, cyc, wec, dinw, addrw);
        chk("mis_sh_err", {31'b0, bus.err}, 32'd1);
        chk("mis_sh_wec", wec, 32'd0);
        step();

        // Word store stalled 10 cycles on RDY=0; stray REQ pulses must be dropped.
        bus.rdy = 1'b0;
        bus.req = 1'b1; bus.op_we = 1'b1; bus.size = 2'b10; bus.addr_in = 32'h48;
        bus.wdata = 32'hCAFEF00D;
        step();
        bus.op_we = 1'b0; bus.addr_in = 32'h100; bus.wdata = 32'h0;
        for (int i = 0; i < 10; i++) begin
            bus.req = i[0];
            step();
            chk("stall_addr", bus.addr, 32'h48);
            chk("stall_din",  bus.din,  32'hCAFEF00D);
            chk("stall_flags", {29'b0, bus.we, bus.busy, bus.done}, 32'b110);
        end
        bus.req = 1'b0;
        bus.rdy = 1'b1;
        step();
        chk("stall_done", {31'b0, bus.done}, 32'd1);
        chk("stall_err",  {31'b0, bus.err},  32'd0);
        step();
        chk("stall_idle", {30'b0, bus.busy, bus.done}, 32'd0);
        step();
        chk("stall_noq",  {31'b0, bus.busy}, 32'd0);

        // Reset during WR_WAIT aborts without DONE.
        bus.rdy = 1'b0;
        bus.req = 1'b1; bus.op_we = 1'b1; bus.size = 2'b10; bus.addr_in = 32'h4C;
        bus.wdata = 32'h11223344;
        step();
        bus.req = 1'b0;
        step();
        chk("rw_we_pre", {31'b0, bus.we}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.rdy = 1'b1;
        chk("rw_we",    {31'b0, bus.we},   32'd0);
        chk("rw_busy",  {31'b0, bus.busy}, 32'd0);
        chk("rw_done",  {31'b0, bus.done}, 32'd0);
        chk("rw_rdata", bus.rdata, 32'h0);
        step();
        chk("rw_nodone", {31'b0, bus.done}, 32'd0);
        run(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, cyc, wec, dinw, addrw);
        chk("rw_load",  bus.rdata, 32'h8899AABB);
        chk("rw_lat",   cyc, 32'd2);
        step();

        // Reset wins over a simultaneous request.
        rst = 1'b1;
        bus.req = 1'b1; bus.op_we = 1'b0; bus.size = 2'b10; bus.addr_in = 32'h40;
        step();
        rst = 1'b0;
        bus.req = 1'b0;
        chk("rp_busy", {31'b0, bus.busy}, 32'd0);
        step();
        chk("rp_idle", {30'b0, bus.busy, bus.done}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter SETTLE, default 1, number of cycles RDY is ignored after ADDR/WE change (range 1..7).
REQ-002 CLK  in  1  rising-edge clock; the only clock in the block.
REQ-003 RST  in  1  synchronous, active-high reset.
REQ-004 REQ  in  1  pipeline request strobe, sampled only while BUSY=0.
REQ-005 OP_WE  in  1  1=store, 0=load.
REQ-006 SIZE  in  2  00=byte, 01=half, 10=word, 11=reserved (treated as word).
REQ-007 UNS  in  1  load zero-extends when 1, sign-extends when 0.
REQ-008 ADDR_IN  in  32  byte address.
REQ-009 WDATA  in  32  store data, right-aligned.
REQ-010 BUSY  out  1  transaction in progress.
REQ-011 DONE  out  1  one-cycle completion pulse.
REQ-012 ERR  out  1  misalignment flag, valid with DONE.
REQ-013 RDATA  out  32  extended load result, valid with DONE, held until next DONE.
REQ-014 ADDR  out  32  word address to cache, ADDR_IN with bits [1:0] forced to 0.
REQ-015 DIN  out  32  write word to cache.
REQ-016 WE  out  1  cache write enable.
REQ-017 DOUT  in  32  read word from cache.
REQ-018 RDY  in  1  cache completion; level signal.

Function
REQ-019 Block SHALL act as initiator on the cache word interface: hold ADDR/DIN/WE stable until completion.
REQ-020 States SHALL be IDLE, RD_SETTLE, RD_WAIT, WR_SETTLE, WR_WAIT, FIN.
REQ-021 IDLE, REQ=1: latch ADDR_IN, WDATA, SIZE, OP_WE, UNS; BUSY=1 next cycle.
REQ-022 Misaligned request (half with ADDR_IN[0]=1; word with ADDR_IN[1:0]!=0) SHALL go to FIN with ERR=1, no cache access, WE never asserted.
REQ-023 Load or sub-word store SHALL enter RD_SETTLE (WE=0); word store SHALL enter WR_SETTLE (WE=1, DIN=WDATA).
REQ-024 Each SETTLE state SHALL last exactly SETTLE cycles, RDY ignored throughout, then advance to its WAIT state.
REQ-025 RD_WAIT: on edge sampling RDY=1 capture DOUT; load goes to FIN; sub-word store merges and goes to WR_SETTLE.
REQ-026 Merge: byte replaces DOUT lane ADDR[1:0] (lane 0 = bits 7:0) with WDATA[7:0]; half replaces lane pair ADDR[1] with WDATA[15:0]; other bits from DOUT.
REQ-027 WR_WAIT: on edge sampling RDY=1 deassert WE and go to FIN.
REQ-028 FIN: DONE=1 for exactly one cycle, BUSY=0 in same cycle, next state IDLE; REQ in FIN ignored.
REQ-029 Load extraction: byte selects lane ADDR[1:0], half selects lane pair ADDR[1], extended per UNS to 32 bits; word passes DOUT unchanged.
REQ-030 Stores SHALL leave RDATA unchanged; ERR=0 on every non-misaligned DONE.
REQ-031 REQ while BUSY=1 SHALL be ignored, not queued.
REQ-032 Latency with RDY=1 immediately, SETTLE=1: REQ at edge 0 -> DONE high cycle after edge 2 for load/word store; edge 4 for sub-word store.
REQ-033 No wait-state limit: RDY held 0 keeps block in WAIT indefinitely with outputs stable.

Reset
REQ-034 RST=1 at an edge SHALL force IDLE; BUSY=0, DONE=0, ERR=0, WE=0, RDATA=0, ADDR=0, DIN=0 after that edge.
REQ-035 RST mid-transaction SHALL abort without DONE; WE low after reset edge; RST has priority over REQ and RDY.

Verification
REQ-036 Cache word 0x40 = 0x8899AABB; load byte signed at 0x42 -> RDATA=0xFFFFFF99, ERR=0, DONE one cycle.
REQ-037 Same word; load half unsigned at 0x42 -> RDATA=0x00008899; load word 0x40 -> 0x8899AABB.
REQ-038 Store byte 0x5A at 0x41 over 0x8899AABB -> one read, then WE pulse writing DIN=0x88995ABB to ADDR=0x40.
REQ-039 Load word at 0x42 -> DONE with ERR=1 cycle after request, WE=0, ADDR unchanged, no RDY wait.
REQ-040 RDY held 0 for 10 cycles during word store -> WE, ADDR, DIN stable, BUSY=1; DONE one cycle after RDY sampled 1; REQ pulses meanwhile ignored.
REQ-041 RST asserted in WR_WAIT -> WE=0, BUSY=0 next cycle, no DONE; subsequent load completes normally.
